dmem_io_responder: RTL and testbench

Memory-side responder for the Riscv151 pipeline: receives the X-stage load/store request (address, store data, write/read enables, func3 size), drives the byte-masked synchronous data memory, and serves memory-mapped I/O (UART, cycle/instruction counters). It returns load data to the M stage one cycle later, already aligned and sign- or zero-extended.

---
 rtl/dmem_io_responder_if.sv | 26 ++
 rtl/dmem_io_responder.sv | 197 +++++++++++++++++++
 tb/tb_dmem_io_responder.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_io_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_io_responder_if
// Brief    : X-stage load/store request bus and M-stage load response.
// Revision : 1.0
// ============================================================================
interface dmem_io_responder_if;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_we;
    logic        req_re;
    logic [2:0]  req_size;
    logic [31:0] rdata;
    logic        misalign_err;

    modport master (
        output req_addr, req_wdata, req_we, req_re, req_size,
        input  rdata, misalign_err
    );

    modport slave (
        input  req_addr, req_wdata, req_we, req_re, req_size,
        output rdata, misalign_err
    );
endinterface
`default_nettype wire

// File: rtl/dmem_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_io_responder
// Brief    : Byte-masked data memory front end plus UART/counter MMIO.
// Revision : 1.0
// ============================================================================
module dmem_io_responder #(
    parameter int DMEM_AWIDTH = 14
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    dmem_io_responder_if.slave          bus,
    input  wire logic                   inst_retire,
    output logic [DMEM_AWIDTH-1:0]      dmem_addr,
    output logic [31:0]                 dmem_wdata,
    output logic [3:0]                  dmem_wmask,
    input  wire logic [31:0]            dmem_rdata,
    output logic [7:0]                  uart_tx_data,
    output logic                        uart_tx_valid,
    input  wire logic                   uart_tx_ready,
    input  wire logic [7:0]             uart_rx_data,
    input  wire logic                   uart_rx_valid,
    output logic                        uart_rx_ready
);

    localparam logic [3:0] C_REGION_DMEM = 4'h1;
    localparam logic [3:0] C_REGION_MMIO = 4'h8;

    localparam logic [7:0] C_OFF_STATUS  = 8'h00;
    localparam logic [7:0] C_OFF_RX      = 8'h04;
    localparam logic [7:0] C_OFF_TX      = 8'h08;
    localparam logic [7:0] C_OFF_CYCLE   = 8'h10;
    localparam logic [7:0] C_OFF_INSTRET = 8'h14;
    localparam logic [7:0] C_OFF_CNT_CLR = 8'h18;

    localparam logic [1:0] C_SZ_B = 2'b00;
    localparam logic [1:0] C_SZ_H = 2'b01;
    localparam logic [1:0] C_SZ_W = 2'b10;

    localparam logic [2:0] C_F3_LB  = 3'b000;
    localparam logic [2:0] C_F3_LH  = 3'b001;
    localparam logic [2:0] C_F3_LW  = 3'b010;
    localparam logic [2:0] C_F3_LBU = 3'b100;
    localparam logic [2:0] C_F3_LHU = 3'b101;

    // Request decode
    logic        w_is_dmem;
    logic        w_is_mmio;
    logic [7:0]  w_off;
    logic [1:0]  w_lo;
    logic [1:0]  w_sz;
    logic        w_misaligned;
    logic        w_mmio_ok;
    logic [3:0]  w_lane_mask;
    logic [31:0] w_lane_wdata;
    logic [31:0] w_mmio_rdata;
    logic        w_tx_store;
    logic        w_cnt_clear;
    logic        w_unused;

    // State
    logic [31:0] r_cycle;
    logic [31:0] r_instret;
    logic        r_tx_valid;
    logic [7:0]  r_tx_data;

    // Load pipeline register
    logic        r_re_q;
    logic        r_is_dmem;
    logic        r_is_mmio;
    logic [1:0]  r_lo;
    logic [2:0]  r_size;
    logic [31:0] r_mmio_q;
    logic        r_misalign;

    // Load extraction
    logic [31:0] w_src;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    assign w_is_dmem = (bus.req_addr[31:28] == C_REGION_DMEM);
    assign w_is_mmio = (bus.req_addr[31:28] == C_REGION_MMIO);
    assign w_off     = bus.req_addr[7:0];
    assign w_lo      = bus.req_addr[1:0];
    assign w_sz      = bus.req_size[1:0];
    assign w_unused  = &{1'b0, bus.req_addr};

    assign w_misaligned = ((w_sz == C_SZ_H) && w_lo[0]) ||
                          ((w_sz == C_SZ_W) && (w_lo != 2'b00));
    assign w_mmio_ok    = w_is_mmio && !w_misaligned;

    always_comb begin
        w_lane_mask  = 4'b0000;
        w_lane_wdata = bus.req_wdata;
        case (w_sz)
            C_SZ_B: begin
                w_lane_mask  = 4'b0001 << w_lo;
                w_lane_wdata = {4{bus.req_wdata[7:0]}};
            end
            C_SZ_H: begin
                w_lane_mask  = 4'b0011 << {w_lo[1], 1'b0};
                w_lane_wdata = {2{bus.req_wdata[15:0]}};
            end
            C_SZ_W: w_lane_mask = 4'b1111;
            default: w_lane_mask = 4'b0000;
        endcase
    end

    assign dmem_addr  = bus.req_addr[DMEM_AWIDTH+1:2];
    assign dmem_wdata = w_lane_wdata;
    assign dmem_wmask = (bus.req_we && w_is_dmem && !w_misaligned) ? w_lane_mask : 4'b0000;

    always_comb begin
        w_mmio_rdata = 32'h0;
        case (w_off)
            C_OFF_STATUS:  w_mmio_rdata = {30'h0, uart_rx_valid, ~r_tx_valid};
            C_OFF_RX:      w_mmio_rdata = {24'h0, uart_rx_data};
            C_OFF_CYCLE:   w_mmio_rdata = r_cycle;
            C_OFF_INSTRET: w_mmio_rdata = r_instret;
            default:       w_mmio_rdata = 32'h0;
        endcase
    end

    // Only full-word or byte reads of the RX register consume the byte.
    assign uart_rx_ready = bus.req_re && w_mmio_ok && (w_off == C_OFF_RX) &&
                           ((bus.req_size == C_F3_LW) || (bus.req_size == C_F3_LB) ||
                            (bus.req_size == C_F3_LBU));

    // A buffer draining this cycle may be refilled on the same edge.
    assign w_tx_store  = bus.req_we && w_mmio_ok && (w_off == C_OFF_TX) &&
                         (!r_tx_valid || uart_tx_ready);
    assign w_cnt_clear = bus.req_we && w_mmio_ok && (w_off == C_OFF_CNT_CLR);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle    <= 32'h0;
            r_instret  <= 32'h0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h0;
            r_re_q     <= 1'b0;
            r_is_dmem  <= 1'b0;
            r_is_mmio  <= 1'b0;
            r_lo       <= 2'b00;
            r_size     <= 3'b000;
            r_mmio_q   <= 32'h0;
            r_misalign <= 1'b0;
        end else begin
            r_cycle <= w_cnt_clear ? 32'h0 : r_cycle + 32'd1;
            if (w_cnt_clear) begin
                r_instret <= 32'h0;
            end else if (inst_retire) begin
                r_instret <= r_instret + 32'd1;
            end

            if (w_tx_store) begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= bus.req_wdata[7:0];
            end else if (uart_tx_ready) begin
                r_tx_valid <= 1'b0;
            end

            r_re_q     <= bus.req_re && !w_misaligned;
            r_is_dmem  <= w_is_dmem;
            r_is_mmio  <= w_is_mmio;
            r_lo       <= w_lo;
            r_size     <= bus.req_size;
            r_mmio_q   <= w_mmio_rdata;
            r_misalign <= (bus.req_we || bus.req_re) && w_misaligned;
        end
    end

    assign w_src  = r_is_dmem ? dmem_rdata : (r_is_mmio ? r_mmio_q : 32'h0);
    assign w_byte = w_src[{r_lo, 3'b000} +: 8];
    assign w_half = r_lo[1] ? w_src[31:16] : w_src[15:0];

    always_comb begin
        w_load_data = 32'h0;
        if (r_re_q) begin
            case (r_size)
                C_F3_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
                C_F3_LH:  w_load_data = {{16{w_half[15]}}, w_half};
                C_F3_LW:  w_load_data = w_src;
                C_F3_LBU: w_load_data = {24'h0, w_byte};
                C_F3_LHU: w_load_data = {16'h0, w_half};
                default:  w_load_data = 32'h0;
            endcase
        end
    end

    assign bus.rdata        = w_load_data;
    assign bus.misalign_err = r_misalign;
    assign uart_tx_data     = r_tx_data;
    assign uart_tx_valid    = r_tx_valid;

endmodule
`default_nettype wire

// File: tb/tb_dmem_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_io_responder
// Brief    : Self-checking bench with a load-result scoreboard and memory model.
// Revision : 1.0
// ============================================================================
module tb_dmem_io_responder;

    localparam int DMEM_AWIDTH = 14;

    logic                   clk;
    logic                   reset;
    logic                   inst_retire;
    logic [DMEM_AWIDTH-1:0] dmem_addr;
    logic [31:0]            dmem_wdata;
    logic [3:0]             dmem_wmask;
    logic [31:0]            dmem_rdata;
    logic [7:0]             uart_tx_data;
    logic                   uart_tx_valid;
    logic                   uart_tx_ready;
    logic [7:0]             uart_rx_data;
    logic                   uart_rx_valid;
    logic                   uart_rx_ready;

    dmem_io_responder_if bus ();

    dmem_io_responder #(.DMEM_AWIDTH(DMEM_AWIDTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .inst_retire   (inst_retire),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_wmask    (dmem_wmask),
        .dmem_rdata    (dmem_rdata),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous byte-masked memory, read-before-write
    logic [31:0] mem [0:(1<<DMEM_AWIDTH)-1];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (dmem_wmask[b]) mem[dmem_addr][8*b +: 8] <= dmem_wdata[8*b +: 8];
        end
        dmem_rdata <= mem[dmem_addr];
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp;

    task automatic drive(input logic [31:0] a, input logic [31:0] wd,
                         input logic we, input logic re, input logic [2:0] sz);
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.req_we    = we;
        bus.req_re    = re;
        bus.req_size  = sz;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_tests += 4;
        if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
        if (bus.misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b want 0", bus.misalign_err); end
        if (uart_tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", uart_tx_valid); end
        if (uart_tx_data !== 8'h0) begin n_fail++; $display("FAIL reset_tx_data: got %h want 0", uart_tx_data); end
        reset = 1'b0;
        drive(32'h8000_0014, 0, 0, 1, 3'b010);
        exp_q.push_back(32'h0);
        tick();
        exp = exp_q.pop_front();
        n_tests++;
        if (bus.rdata !== exp) begin n_fail++; $display("FAIL reset_instret: got %h want %h", bus.rdata, exp); end
    endtask

    task automatic test_loads();
        logic [31:0] addrs [4] = '{32'h1000_0003, 32'h1000_0003, 32'h1000_0002, 32'h1000_0002};
        logic [2:0]  sizes [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] exps  [4] = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD, 32'h0000_DEAD};
        drive(32'h1000_0000, 32'hDEAD_BEEF, 1, 0, 3'b010);
        #1;
        n_tests++;
        if (dmem_wmask !== 4'b1111) begin n_fail++; $display("FAIL sw_mask: got %b want 1111", dmem_wmask); end
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(addrs[i], 0, 0, 1, sizes[i]);
            exp_q.push_back(exps[i]);
            tick();
            exp = exp_q.pop_front();
            n_tests++;
            if (bus.rdata !== exp) begin n_fail++; $display("FAIL load_ext[%0d]: got %h want %h", i, bus.rdata, exp); end
        end
        drive(32'h1000_0001, 32'h0000_0012, 1, 0, 3'b000);
        #1;
        n_tests++;
        if (dmem_wmask !== 4'b0010) begin n_fail++; $display("FAIL sb_mask: got %b want 0010", dmem_wmask); end
        tick();
        drive(32'h1000_0000, 0, 0, 1, 3'b010);
        exp_q.push_back(32'hDEAD_12EF);
        tick();
        exp = exp_q.pop_front();
        n_tests++;
        if (bus.rdata !== exp) begin n_fail++; $display("FAIL sb_readback: got %h want %h", bus.rdata, exp); end
    endtask

    task automatic test_back_to_back();
        drive(32'h1000_0004, 32'hCAFE_F00D, 1, 0, 3'b010);
        tick();
        drive(32'h1000_0004, 32'h1122_3344, 1, 1, 3'b010);
        exp_q.push_back(32'hCAFE_F00D);
        tick();
        exp = exp_q.pop_front();
        n_tests++;
        if (bus.rdata !== exp) begin n_fail++; $display("FAIL rw_old: got %h want %h", bus.rdata, exp); end
        drive(32'h1000_0004, 0, 0, 1, 3'b010);
        exp_q.push_back(32'h1122_3344);
        tick();
        exp = exp_q.pop_front();
        n_tests++;
        if (bus.rdata !== exp) begin n_fail++; $display("FAIL rw_new: got %h want %h", bus.rdata, exp); end
    endtask

    task automatic test_misalign();
        drive(32'h1000_0001, 32'h0000_ABCD, 1, 0, 3'b001);
        #1;
        n_tests++;
        if (dmem_wmask !== 4'b0000) begin n_fail++; $display("FAIL mis_mask: got %b want 0000", dmem_wmask); end
        tick();
        n_tests++;
        if (bus.misalign_err !== 1'b1) begin n_fail++; $display("FAIL mis_pulse: got %b want 1", bus.misalign_err); end
        drive(32'h1000_0000, 0, 0, 1, 3'b010);
        exp_q.push_back(32'hDEAD_12EF);
        tick();
        exp = exp_q.pop_front();
        n_tests += 2;
        if (bus.rdata !== exp) begin n_fail++; $display("FAIL mis_mem: got %h want %h", bus.rdata, exp); end
        if (bus.misalign_err !== 1'b0) begin n_fail++; $display("FAIL mis_clear: got %b want 0", bus.misalign_err); end
        drive(32'h1000_0002, 0, 0, 1, 3'b010);
        exp_q.push_back(32'h0);
        tick();
        exp = exp_q.pop_front();
        n_tests += 2;
        if (bus.rdata !== exp) begin n_fail++; $display("FAIL mis_lw_data: got %h want %h", bus.rdata, exp); end
        if (bus.misalign_err !== 1'b1) begin n_fail++; $display("FAIL mis_lw_pulse: got %b want 1", bus.misalign_err); end
    endtask

    task automatic test_unmapped();
        drive(32'h2000_0000, 32'h5555_5555, 1, 0, 3'b010);
        #1;
        n_tests++;
        if (dmem_wmask !== 4'b0000) begin n_fail++; $display("FAIL unmap_mask: got %b want 0000", dmem_wmask); end
        tick();
        drive(32'h2000_0000, 0, 0, 1, 3'b010);
        exp_q.push_back(32'h0);
        tick();
        exp = exp_q.pop_front();
        n_tests++;
        if (bus.rdata !== exp) begin n_fail++; $display("FAIL unmap_load: got %h want %h", bus.rdata, exp); end
    endtask

    task automatic test_tx();
        uart_tx_ready = 1'b0;
        drive(32'h8000_0008, 32'h0000_0041, 1, 0, 3'b000);
        tick();
        n_tests += 2;
        if (uart_tx_valid !== 1'b1) begin n_fail++; $display("FAIL tx_set: got %b want 1", uart_tx_valid); end
        if (uart_tx_data !== 8'h41) begin n_fail++; $display("FAIL tx_data: got %h want 41", uart_tx_data); end
        drive(32'h8000_0000, 0, 0, 1, 3'b010);
        exp_q.push_back(32'h0);
        tick();
        exp = exp_q.pop_front();
        n_tests++;
        if (bus.rdata !== exp) begin n_fail++; $display("FAIL tx_status_busy: got %h want %h", bus.rdata, exp); end
        drive(32'h8000_0008, 32'h0000_0055, 1, 0, 3'b000);
        tick();
        n_tests += 2;
        if (uart_tx_data !== 8'h41) begin n_fail++; $display("FAIL tx_drop: got %h want 41", uart_tx_data); end
        if (uart_tx_valid !== 1'b1) begin n_fail++; $display("FAIL tx_hold: got %b want 1", uart_tx_valid); end
        uart_tx_ready = 1'b1;
        drive(0, 0, 0, 0, 3'b000);
        tick();
        uart_tx_ready = 1'b0;
        n_tests++;
        if (uart_tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_drain: got %b want 0", uart_tx_valid); end
        drive(32'h8000_0000, 0, 0, 1, 3'b010);
        exp_q.push_back(32'h1);
        tick();
        exp = exp_q.pop_front();
        n_tests++;
        if (bus.rdata !== exp) begin n_fail++; $display("FAIL tx_status_free: got %h want %h", bus.rdata, exp); end
        // Drain and refill on the same edge
        drive(32'h8000_0008, 32'h0000_0061, 1, 0, 3'b000);
        tick();
        uart_tx_ready = 1'b1;
        drive(32'h8000_0008, 32'h0000_0077, 1, 0, 3'b000);
        tick();
        n_tests += 2;
        if (uart_tx_valid !== 1'b1) begin n_fail++; $display("FAIL tx_refill_valid: got %b want 1", uart_tx_valid); end
        if (uart_tx_data !== 8'h77) begin n_fail++; $display("FAIL tx_refill_data: got %h want 77", uart_tx_data); end
        drive(0, 0, 0, 0, 3'b000);
        tick();
        uart_tx_ready = 1'b0;
    endtask

    task automatic test_rx();
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'hA5;
        drive(32'h8000_0004, 0, 0, 1, 3'b010);
        #1;
        n_tests++;
        if (uart_rx_ready !== 1'b1) begin n_fail++; $display("FAIL rx_ready_lw: got %b want 1", uart_rx_ready); end
        exp_q.push_back(32'h0000_00A5);
        tick();
        exp = exp_q.pop_front();
        n_tests++;
        if (bus.rdata !== exp) begin n_fail++; $display("FAIL rx_data: got %h want %h", bus.rdata, exp); end
        drive(32'h8000_0004, 0, 0, 1, 3'b001);
        #1;
        n_tests++;
        if (uart_rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_ready_lh: got %b want 0", uart_rx_ready); end
        tick();
        drive(32'h8000_0000, 0, 0, 1, 3'b010);
        exp_q.push_back(32'h3);
        tick();
        exp = exp_q.pop_front();
        n_tests++;
        if (bus.rdata !== exp) begin n_fail++; $display("FAIL rx_status: got %h want %h", bus.rdata, exp); end
        uart_rx_valid = 1'b0;
    endtask

    task automatic test_counters();
        logic [31:0] cnt_exp [4] = '{32'd100, 32'd50, 32'd1, 32'd0};
        inst_retire = 1'b1;
        drive(32'h8000_0018, 0, 1, 0, 3'b010);
        tick();
        drive(0, 0, 0, 0, 3'b000);
        for (int i = 0; i < 100; i++) begin
            inst_retire = (i % 2 == 0);
            tick();
        end
        inst_retire = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                inst_retire = 1'b1;
                drive(32'h8000_0018, 0, 1, 0, 3'b010);
                tick();
                inst_retire = 1'b0;
                drive(0, 0, 0, 0, 3'b000);
                tick();
            end
            drive((i % 2 == 0) ? 32'h8000_0010 : 32'h8000_0014, 0, 0, 1, 3'b010);
            exp_q.push_back(cnt_exp[i]);
            tick();
            exp = exp_q.pop_front();
            n_tests++;
            if (bus.rdata !== exp) begin n_fail++; $display("FAIL counter[%0d]: got %0d want %0d", i, bus.rdata, exp); end
        end
    endtask

    task automatic test_wrap();
        force dut.r_cycle = 32'hFFFF_FFFF;
        #1;
        release dut.r_cycle;
        drive(32'h8000_0010, 0, 0, 1, 3'b010);
        exp_q.push_back(32'hFFFF_FFFF);
        tick();
        exp = exp_q.pop_front();
        n_tests++;
        if (bus.rdata !== exp) begin n_fail++; $display("FAIL wrap_max: got %h want %h", bus.rdata, exp); end
        exp_q.push_back(32'h0);
        tick();
        exp = exp_q.pop_front();
        n_tests++;
        if (bus.rdata !== exp) begin n_fail++; $display("FAIL wrap_zero: got %h want %h", bus.rdata, exp); end
    endtask

    task automatic test_reset_mid();
        uart_tx_ready = 1'b0;
        drive(32'h8000_0008, 32'h0000_005A, 1, 0, 3'b000);
        tick();
        n_tests++;
        if (uart_tx_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pending: got %b want 1", uart_tx_valid); end
        drive(32'h1000_0000, 0, 0, 1, 3'b010);
        reset = 1'b1;
        exp_q.push_back(32'h0);
        tick();
        reset = 1'b0;
        drive(0, 0, 0, 0, 3'b000);
        exp = exp_q.pop_front();
        n_tests += 2;
        if (bus.rdata !== exp) begin n_fail++; $display("FAIL rstmid_rdata: got %h want %h", bus.rdata, exp); end
        if (uart_tx_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_tx_valid: got %b want 0", uart_tx_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset         = 1'b1;
        inst_retire   = 1'b0;
        uart_tx_ready = 1'b0;
        uart_rx_valid = 1'b0;
        uart_rx_data  = 8'h00;
        drive(0, 0, 0, 0, 3'b000);
        repeat (2) tick();
        test_reset();
        test_loads();
        test_back_to_back();
        test_misalign();
        test_unmapped();
        test_tx();
        test_rx();
        test_counters();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
